// File: rtl/tdc_uart_pkg.sv
// Shared types, defaults and helpers for the TDC UART transmit/receive blocks.
package tdc_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_e;

    localparam int unsigned UART_CLKS_PER_BIT = 16;
    localparam int unsigned UART_DATA_BITS    = 8;

    // Even parity over the low nbits of data (XOR of the transmitted data bits).
    function automatic logic even_parity(input logic [7:0] data, input int nbits);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < nbits) p = p ^ data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module uart_baud_gen
    import tdc_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic bit_tick_o
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bit_tick_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/tdc_uart_tx.sv
// UART transmitter: one-entry holding register, start/data/parity/stop framing, registered tx line.
module tdc_uart_tx
    import tdc_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    generate
        if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
            PARITY_EN > 1 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
            $error("tdc_uart_tx: illegal parameter combination");
        end
    endgenerate

    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    uart_tx_state_e state_q, state_d;
    logic [7:0]     hold_q, hold_d;
    logic           hold_full_q, hold_full_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic           tx_q, tx_d;

    logic bit_tick;
    logic accept;
    logic load;
    logic frame_done_c;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == ST_IDLE),
        .enable_i  (state_q != ST_IDLE),
        .bit_tick_o(bit_tick)
    );

    assign accept = tx_valid && !hold_full_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d      = state_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        bit_cnt_d    = bit_cnt_q;
        tx_d         = tx_q;
        load         = 1'b0;
        frame_done_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (hold_full_q) load = 1'b1;
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = 3'd0;
                        if (PARITY_EN != 0) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) begin
                    state_d   = ST_STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        frame_done_c = 1'b1;
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Reload from hold: shared by the idle start and the gapless back-to-back start.
        if (load) begin
            state_d   = ST_START;
            shift_d   = hold_q;
            parity_d  = even_parity(hold_q, int'(DATA_BITS));
            bit_cnt_d = 3'd0;
            tx_d      = 1'b0;
        end
    end

    // A new byte entering hold wins over the reload that empties it.
    always_comb begin
        hold_d      = accept ? tx_data : hold_q;
        hold_full_d = hold_full_q;
        if (accept)    hold_full_d = 1'b1;
        else if (load) hold_full_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            bit_cnt_q   <= 3'd0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
        end
    end

    assign tx_ready   = !hold_full_q;
    assign tx         = tx_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_c;

endmodule
